// File: rtl/cordic_pkg.sv
// cordic_pkg -- constants and helpers shared by the CORDIC units (atan_cordic, cos).
//   DATA_W/FRAC_W : signed Q3.30 datapath geometry
//   atan_q30()    : atan(2^-i) in Q.30, i = 0..29
//   float32 field widths, exponent bias, canonical NaN
//   state_t       : sequencer states of the iterative units
package cordic_pkg;

  localparam int DATA_W = 34;
  localparam int FRAC_W = 30;

  localparam int          F_EXP_W   = 8;
  localparam int          F_MAN_W   = 23;
  localparam int          F_BIAS    = 127;
  localparam logic [31:0] F_QNAN    = 32'h7FC0_0000;

  localparam logic signed [DATA_W-1:0] ONE_Q30 = 34'sh0_4000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_ITER = 2'd2,
    S_PACK = 2'd3
  } state_t;

  // atan(2^-i) scaled by 2^30, rounded to nearest
  function automatic logic signed [DATA_W-1:0] atan_q30(input logic [4:0] i);
    case (i)
      5'd0:    return 34'sd843314857;
      5'd1:    return 34'sd497837829;
      5'd2:    return 34'sd263043837;
      5'd3:    return 34'sd133525159;
      5'd4:    return 34'sd67021687;
      5'd5:    return 34'sd33543516;
      5'd6:    return 34'sd16775851;
      5'd7:    return 34'sd8388437;
      5'd8:    return 34'sd4194283;
      5'd9:    return 34'sd2097149;
      5'd10:   return 34'sd1048576;
      5'd11:   return 34'sd524288;
      5'd12:   return 34'sd262144;
      5'd13:   return 34'sd131072;
      5'd14:   return 34'sd65536;
      5'd15:   return 34'sd32768;
      5'd16:   return 34'sd16384;
      5'd17:   return 34'sd8192;
      5'd18:   return 34'sd4096;
      5'd19:   return 34'sd2048;
      5'd20:   return 34'sd1024;
      5'd21:   return 34'sd512;
      5'd22:   return 34'sd256;
      5'd23:   return 34'sd128;
      5'd24:   return 34'sd64;
      5'd25:   return 34'sd32;
      5'd26:   return 34'sd16;
      5'd27:   return 34'sd8;
      5'd28:   return 34'sd4;
      5'd29:   return 34'sd2;
      default: return 34'sd0;
    endcase
  endfunction

endpackage

// File: rtl/fix_to_float.sv
// fix_to_float -- combinational signed Q3.30 to float32 conversion.
//   i_fix   : signed 34-bit Q3.30 value
//   o_float : float32, mantissa truncated toward zero; zero maps to +0
module fix_to_float
  import cordic_pkg::*;
(
  input  logic signed [DATA_W-1:0] i_fix,
  output logic        [31:0]       o_float
);

  logic              w_sign;
  logic [DATA_W-1:0] w_mag;
  logic [5:0]        w_pos;
  logic [7:0]        w_exp;
  logic [22:0]       w_man;

  // leading-one detect and normalise the magnitude
  always_comb begin
    w_sign = i_fix[DATA_W-1];
    w_mag  = w_sign ? unsigned'(-i_fix) : unsigned'(i_fix);
    w_pos  = 6'd0;
    for (int k = 0; k < DATA_W; k++) begin
      w_pos = w_mag[k] ? 6'(k) : w_pos;
    end
    // exponent 127 + p - 30
    w_exp = 8'd97 + {2'b00, w_pos};
    // move the leading one to bit 33; the 23 bits beneath it are the mantissa
    w_man = 23'((w_mag << (6'd33 - w_pos)) >> 10);
    if (w_mag == 34'd0) begin
      o_float = 32'h0000_0000;
    end else begin
      o_float = {w_sign, w_exp, w_man};
    end
  end

endmodule

// File: rtl/atan_cordic.sv
// atan_cordic -- iterative vectoring-mode CORDIC, result = atan(dataa), float32 in/out.
//   clk, reset (sync, active high), clk_en (low freezes every register)
//   start     : request, sampled in IDLE only
//   dataa     : float32 operand, captured when start is accepted
//   busy      : high from the accepting edge until done rises
//   done      : one enabled-cycle pulse, result valid
//   result    : float32 angle in radians, held until the next done
//   range_err : |a| > 1, inf or NaN; valid with done
module atan_cordic
  import cordic_pkg::*;
#(
  parameter int ITER = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        range_err
);

  localparam logic [4:0] CNT_LAST = 5'(ITER - 1);

  state_t                    r_state;
  logic [4:0]                r_cnt;
  logic [31:0]               r_a;
  logic signed [DATA_W-1:0]  r_x, r_y, r_z;
  logic                      r_nan, r_bypass, r_over;

  logic                      w_sign;
  logic [7:0]                w_exp;
  logic [22:0]               w_frac;
  logic [DATA_W-1:0]         w_mant, w_mag;
  logic signed [DATA_W-1:0]  w_y0;
  logic                      w_is_nan, w_over, w_small;
  logic signed [DATA_W-1:0]  w_xs, w_ys, w_atan;
  logic signed [DATA_W-1:0]  w_x_nx, w_y_nx, w_z_nx;
  logic [31:0]               w_fl;

  assign w_sign = r_a[31];
  assign w_exp  = r_a[30:23];
  assign w_frac = r_a[22:0];

  // float -> Q3.30 unpack and operand classification
  always_comb begin
    w_is_nan = (w_exp == 8'hFF) && (w_frac != 23'd0);
    // covers inf and NaN too (exponent 255)
    w_over   = (w_exp > 8'd127) || ((w_exp == 8'd127) && (w_frac != 23'd0));
    w_small  = (w_exp < 8'd115);
    w_mant   = {10'd0, 1'b1, w_frac};
    // value = mant * 2^(e-150); in Q.30 that is mant shifted by (e-120)
    if (w_over) begin
      w_mag = unsigned'(ONE_Q30);
    end else if (w_exp >= 8'd120) begin
      w_mag = w_mant << (w_exp - 8'd120);
    end else if (w_exp == 8'd0) begin
      w_mag = 34'd0;
    end else begin
      w_mag = w_mant >> (8'd120 - w_exp);
    end
    w_y0 = w_sign ? -$signed(w_mag) : $signed(w_mag);
  end

  // one vectoring micro-rotation, driving y toward zero
  always_comb begin
    w_xs   = r_x >>> r_cnt;
    w_ys   = r_y >>> r_cnt;
    w_atan = atan_q30(r_cnt);
    if (!r_y[DATA_W-1]) begin
      w_x_nx = r_x + w_ys;
      w_y_nx = r_y - w_xs;
      w_z_nx = r_z + w_atan;
    end else begin
      w_x_nx = r_x - w_ys;
      w_y_nx = r_y + w_xs;
      w_z_nx = r_z - w_atan;
    end
  end

  fix_to_float u_pack (
    .i_fix   (r_z),
    .o_float (w_fl)
  );

  // sequencer, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 5'd0;
      r_a       <= 32'd0;
      r_x       <= 34'sd0;
      r_y       <= 34'sd0;
      r_z       <= 34'sd0;
      r_nan     <= 1'b0;
      r_bypass  <= 1'b0;
      r_over    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= 32'd0;
      range_err <= 1'b0;
    end else if (clk_en) begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= dataa;
            busy    <= 1'b1;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          r_x      <= ONE_Q30;
          r_y      <= w_y0;
          r_z      <= 34'sd0;
          r_cnt    <= 5'd0;
          r_nan    <= w_is_nan;
          r_bypass <= w_small;
          r_over   <= w_over;
          r_state  <= S_ITER;
        end
        S_ITER: begin
          r_x <= w_x_nx;
          r_y <= w_y_nx;
          r_z <= w_z_nx;
          if (r_cnt == CNT_LAST) begin
            r_state <= S_PACK;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        S_PACK: begin
          // bypass returns the operand bit-exact: atan(a) = a to within 1 ulp here
          if (r_nan) begin
            result <= F_QNAN;
          end else if (r_bypass) begin
            result <= r_a;
          end else begin
            result <= w_fl;
          end
          range_err <= r_over;
          done      <= 1'b1;
          busy      <= 1'b0;
          r_cnt     <= 5'd0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
